// File: rtl/exec_pkg.sv
// Shared types for the registered execute stage: opcodes, branch conditions
// and the multiply-sequencing states.
package exec_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_XOR  = 4'd2,
    OP_ANDN = 4'd3,
    OP_ROL  = 4'd4,
    OP_SLL  = 4'd5,
    OP_ROR  = 4'd6,
    OP_SRL  = 4'd7,
    OP_SEQ  = 4'd8,
    OP_SLT  = 4'd9,
    OP_SLE  = 4'd10,
    OP_SCO  = 4'd11,
    OP_BTR  = 4'd12,
    OP_LBI  = 4'd13,
    OP_SLBI = 4'd14,
    OP_MUL  = 4'd15
  } op_t;

  typedef enum logic [1:0] {
    BR_EQZ = 2'd0,
    BR_NEZ = 2'd1,
    BR_LTZ = 2'd2,
    BR_GEZ = 2'd3
  } brch_cond_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL      = 2'd1,
    ST_MUL_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/exec_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, low WIDTH
// bits of the unsigned product; holds the result until the consumer acks.
module exec_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_ack,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product
);

  localparam int CNT_W = $clog2(WIDTH);
  // Bit 0 is folded in at start and the last bit is summed combinationally,
  // so the product is available WIDTH-1 cycles after start.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 2);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_hold;

  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_sum;

  assign w_step    = r_b[0] ? r_a : '0;
  assign w_sum     = r_acc + w_step;
  assign o_busy    = r_busy;
  assign o_done    = r_hold || (r_busy && (r_cnt == '0));
  assign o_product = r_hold ? r_acc : w_sum;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_hold <= 1'b0;
    end else if (i_abort) begin
      r_busy <= 1'b0;
      r_hold <= 1'b0;
    end else if (i_start) begin
      r_acc  <= i_b[0] ? i_a : '0;
      r_a    <= i_a << 1;
      r_b    <= i_b >> 1;
      r_cnt  <= CNT_LOAD;
      r_busy <= 1'b1;
      r_hold <= 1'b0;
    end else if (r_busy) begin
      r_acc <= w_sum;
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
        r_hold <= !i_ack;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end else if (r_hold && i_ack) begin
      r_hold <= 1'b0;
    end
  end

endmodule

// File: rtl/execute_pipe.sv
// Registered execute stage: ALU, branch/jump resolution with a one-cycle
// redirect pulse, EX/MEM output register and an iterative multiply.
//
// state       | meaning
// ST_IDLE     | accepting instructions
// ST_MUL      | multiplier iterating, in_ready low
// ST_MUL_DONE | product ready, waiting for EX/MEM to free up
module execute_pipe
  import exec_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int RD_W   = 3,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_t              in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [WIDTH-1:0] in_pc_inc,
  input  logic             in_brch_en,
  input  brch_cond_t       in_brch_cond,
  input  logic             in_jmp,
  input  logic             in_jmp_reg,
  input  logic             in_link,
  input  logic [RD_W-1:0]  in_rd,
  input  logic             in_wr_en,
  input  logic             out_stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_result,
  output logic [RD_W-1:0]  out_rd,
  output logic             out_wr_en,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc
);

  localparam int SH_W = $clog2(WIDTH);
  localparam logic [SH_W:0] L_SH_FULL = (SH_W + 1)'(WIDTH);

  state_t r_state;
  state_t w_state_nxt;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [RD_W-1:0]  r_rd;
  logic             r_wr_en;
  logic             r_redir_valid;
  logic [WIDTH-1:0] r_redir_pc;
  logic [RD_W-1:0]  r_mul_rd;
  logic             r_mul_wr_en;

  logic             w_free;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_mul_start;
  logic             w_mul_load;
  logic             w_mul_busy;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_product;

  logic [WIDTH:0]   w_add_c;
  logic [SH_W-1:0]  w_sh;
  logic [SH_W:0]    w_sh_inv;
  logic             w_eq;
  logic             w_lt;
  logic [WIDTH-1:0] w_btr;
  logic [WIDTH-1:0] w_alu;
  logic             w_cond;
  logic             w_taken;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_result;

  assign w_free      = !(r_out_valid && out_stall);
  assign in_ready    = (r_state == ST_IDLE) && !w_mul_busy && w_free && !flush;
  assign w_accept    = in_valid && in_ready;
  assign w_is_mul    = (MUL_EN != 0) && (in_op == OP_MUL);
  assign w_mul_start = w_accept && w_is_mul;
  assign w_mul_load  = (r_state != ST_IDLE) && w_mul_done && w_free && !flush;

  exec_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_mul_start),
    .i_abort   (flush),
    .i_ack     (w_free),
    .i_a       (in_a),
    .i_b       (in_b),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (w_mul_start) w_state_nxt = ST_MUL;
      ST_MUL:      if (w_mul_done) w_state_nxt = w_free ? ST_IDLE : ST_MUL_DONE;
      ST_MUL_DONE: if (w_free) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
    if (flush) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // A zero shift yields a complementary shift of WIDTH, which clears to 0.
  assign w_add_c  = {1'b0, in_a} + {1'b0, in_b};
  assign w_sh     = in_b[SH_W-1:0];
  assign w_sh_inv = L_SH_FULL - {1'b0, w_sh};
  assign w_eq     = (in_a == in_b);
  assign w_lt     = ($signed(in_a) < $signed(in_b));

  always_comb begin
    w_btr = '0;
    for (int i = 0; i < WIDTH; i++) w_btr[i] = in_a[WIDTH-1-i];
  end

  always_comb begin
    w_alu = w_add_c[WIDTH-1:0];
    case (in_op)
      OP_ADD:  w_alu = w_add_c[WIDTH-1:0];
      OP_SUB:  w_alu = in_b - in_a;
      OP_XOR:  w_alu = in_a ^ in_b;
      OP_ANDN: w_alu = in_a & ~in_b;
      OP_ROL:  w_alu = (in_a << w_sh) | (in_a >> w_sh_inv);
      OP_SLL:  w_alu = in_a << w_sh;
      OP_ROR:  w_alu = (in_a >> w_sh) | (in_a << w_sh_inv);
      OP_SRL:  w_alu = in_a >> w_sh;
      OP_SEQ:  w_alu = {{(WIDTH-1){1'b0}}, w_eq};
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, w_lt};
      OP_SLE:  w_alu = {{(WIDTH-1){1'b0}}, w_lt | w_eq};
      OP_SCO:  w_alu = {{(WIDTH-1){1'b0}}, w_add_c[WIDTH]};
      OP_BTR:  w_alu = w_btr;
      OP_LBI:  w_alu = in_imm;
      OP_SLBI: w_alu = (in_a << 8) | WIDTH'(in_imm[7:0]);
      OP_MUL:  w_alu = w_add_c[WIDTH-1:0];
      default: w_alu = w_add_c[WIDTH-1:0];
    endcase
  end

  always_comb begin
    w_cond = 1'b0;
    case (in_brch_cond)
      BR_EQZ:  w_cond = (in_a == '0);
      BR_NEZ:  w_cond = (in_a != '0);
      BR_LTZ:  w_cond = in_a[WIDTH-1];
      BR_GEZ:  w_cond = !in_a[WIDTH-1];
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken  = in_jmp || (in_brch_en && w_cond);
  assign w_target = (in_jmp_reg ? in_a : in_pc_inc) + in_imm;
  assign w_result = in_link ? in_pc_inc : w_alu;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mul_rd    <= '0;
      r_mul_wr_en <= 1'b0;
    end else if (w_mul_start) begin
      r_mul_rd    <= in_rd;
      r_mul_wr_en <= in_wr_en;
    end
  end

  // Redirect is a pulse: it is only ever set on the accept edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_valid   <= 1'b0;
      r_result      <= '0;
      r_rd          <= '0;
      r_wr_en       <= 1'b0;
      r_redir_valid <= 1'b0;
      r_redir_pc    <= '0;
    end else begin
      r_redir_valid <= 1'b0;
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_accept && !w_is_mul) begin
        r_out_valid   <= 1'b1;
        r_result      <= w_result;
        r_rd          <= in_rd;
        r_wr_en       <= in_wr_en;
        r_redir_valid <= w_taken;
        if (w_taken) r_redir_pc <= w_target;
      end else if (w_mul_load) begin
        r_out_valid <= 1'b1;
        r_result    <= w_mul_product;
        r_rd        <= r_mul_rd;
        r_wr_en     <= r_mul_wr_en;
      end else if (w_free) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid      = r_out_valid;
  assign out_result     = r_result;
  assign out_rd         = r_rd;
  assign out_wr_en      = r_wr_en & r_out_valid;
  assign redirect_valid = r_redir_valid;
  assign redirect_pc    = r_redir_pc;

endmodule

// File: tb/tb_execute_pipe.sv
// Bench for execute_pipe: directed vector table, hand-written multi-cycle
// sequences and random instructions against an arithmetic reference model.
module tb_execute_pipe;
  import exec_pkg::*;

  localparam int W = 16;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  op_t           in_op;
  logic [W-1:0]  in_a, in_b, in_imm, in_pc_inc;
  logic          in_brch_en;
  brch_cond_t    in_brch_cond;
  logic          in_jmp, in_jmp_reg, in_link;
  logic [2:0]    in_rd;
  logic          in_wr_en;
  logic          out_stall;
  logic          flush;
  logic          out_valid;
  logic [W-1:0]  out_result;
  logic [2:0]    out_rd;
  logic          out_wr_en;
  logic          redirect_valid;
  logic [W-1:0]  redirect_pc;

  int checks = 0;
  int errors = 0;

  execute_pipe #(.WIDTH(W), .RD_W(3), .MUL_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
    .in_pc_inc(in_pc_inc), .in_brch_en(in_brch_en), .in_brch_cond(in_brch_cond),
    .in_jmp(in_jmp), .in_jmp_reg(in_jmp_reg), .in_link(in_link),
    .in_rd(in_rd), .in_wr_en(in_wr_en), .out_stall(out_stall), .flush(flush),
    .out_valid(out_valid), .out_result(out_result), .out_rd(out_rd),
    .out_wr_en(out_wr_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    op_t        op;
    logic [15:0] a, b, imm, pc;
    logic       br;
    brch_cond_t cond;
    logic       jmp, jreg, link;
    logic [2:0] rd;
    logic       wr;
    logic [15:0] exp_res;
    logic       exp_redir;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(op_t op, logic [15:0] a, logic [15:0] b,
                              logic [15:0] imm, logic [15:0] pc, logic br,
                              brch_cond_t cond, logic jmp, logic jreg, logic link,
                              logic [15:0] res, logic redir, logic [15:0] tpc);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.imm = imm; v.pc = pc; v.br = br;
    v.cond = cond; v.jmp = jmp; v.jreg = jreg; v.link = link;
    v.rd = 3'd0; v.wr = 1'b0;
    v.exp_res = res; v.exp_redir = redir; v.exp_pc = tpc;
    return v;
  endfunction

  // Reference model: plain integer arithmetic on the instruction rules.
  function automatic int sgn(logic [15:0] x);
    return (x >= 16'h8000) ? int'(x) - 65536 : int'(x);
  endfunction

  function automatic logic [15:0] m_alu(op_t op, logic [15:0] a, logic [15:0] b,
                                         logic [15:0] imm);
    longint unsigned ua = longint'(a);
    longint unsigned ub = longint'(b);
    longint unsigned s  = ub % 16;
    longint unsigned r  = 0;
    case (op)
      OP_ADD:  r = ua + ub;
      OP_SUB:  r = ub + 65536 - ua;
      OP_XOR:  r = ua ^ ub;
      OP_ANDN: r = ua & ~ub;
      OP_ROL:  r = (ua << s) | (ua >> (16 - s));
      OP_SLL:  r = ua << s;
      OP_ROR:  r = (ua >> s) | (ua << (16 - s));
      OP_SRL:  r = ua >> s;
      OP_SEQ:  r = (sgn(a) == sgn(b)) ? 1 : 0;
      OP_SLT:  r = (sgn(a) <  sgn(b)) ? 1 : 0;
      OP_SLE:  r = (sgn(a) <= sgn(b)) ? 1 : 0;
      OP_SCO:  r = (ua + ub) / 65536;
      OP_BTR:  for (int i = 0; i < 16; i++) if (a[i]) r = r + (64'd1 << (15 - i));
      OP_LBI:  r = longint'(imm);
      OP_SLBI: r = ua * 256 + (longint'(imm) % 256);
      OP_MUL:  r = ua * ub;
      default: r = 0;
    endcase
    return 16'(r % 65536);
  endfunction

  function automatic logic m_taken(logic br, brch_cond_t c, logic jmp, logic [15:0] a);
    int sa = sgn(a);
    logic t;
    case (c)
      BR_EQZ:  t = (sa == 0);
      BR_NEZ:  t = (sa != 0);
      BR_LTZ:  t = (sa < 0);
      default: t = (sa >= 0);
    endcase
    return jmp || (br && t);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic set_in(vec_t v);
    in_op = v.op; in_a = v.a; in_b = v.b; in_imm = v.imm; in_pc_inc = v.pc;
    in_brch_en = v.br; in_brch_cond = v.cond; in_jmp = v.jmp;
    in_jmp_reg = v.jreg; in_link = v.link; in_rd = v.rd; in_wr_en = v.wr;
  endtask

  task automatic run_vec(vec_t v, string nm);
    @(negedge clk);
    set_in(v);
    in_valid = 1'b1;
    #1 chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk({nm, " out_valid"}, 32'(out_valid), 32'd1);
    chk({nm, " result"}, 32'(out_result), 32'(v.exp_res));
    chk({nm, " redirect_valid"}, 32'(redirect_valid), 32'(v.exp_redir));
    if (v.exp_redir) chk({nm, " redirect_pc"}, 32'(redirect_pc), 32'(v.exp_pc));
    chk({nm, " rd"}, 32'(out_rd), 32'(v.rd));
    chk({nm, " wr_en"}, 32'(out_wr_en), 32'(v.wr));
  endtask

  task automatic start_mul(logic [15:0] a, logic [15:0] b, logic [2:0] rd);
    vec_t v;
    v = mk(OP_MUL, a, b, 16'h0, 16'h0, 1'b0, BR_EQZ, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    v.rd = rd; v.wr = 1'b1;
    @(negedge clk);
    set_in(v);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic do_mul(logic [15:0] a, logic [15:0] b, logic [2:0] rd, string nm);
    int lat;
    int rdy_bad;
    start_mul(a, b, rd);
    lat = 1;
    rdy_bad = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_bad++;
      @(posedge clk);
      #1 lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'd16);
    chk({nm, " product"}, 32'(out_result), 32'(m_alu(OP_MUL, a, b, 16'h0)));
    chk({nm, " rd"}, 32'(out_rd), 32'(rd));
    chk({nm, " ready_during_mul"}, 32'(rdy_bad), 32'd0);
    chk({nm, " ready_after"}, 32'(in_ready), 32'd1);
  endtask

  task automatic watch_no_valid(int n, string nm);
    int seen = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    chk(nm, 32'(seen), 32'd0);
  endtask

  initial begin
    vec_t v;
    rst = 1'b0; in_valid = 1'b0; out_stall = 1'b0; flush = 1'b0;
    v = mk(OP_ADD, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, BR_EQZ, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    set_in(v);

    tbl[0]  = mk(OP_ADD,  16'h0005, 16'h0003, 16'h0000, 16'h0000, 0, BR_EQZ, 0, 0, 0, 16'h0008, 0, 16'h0000);
    tbl[1]  = mk(OP_SUB,  16'h0003, 16'h0005, 16'h0000, 16'h0000, 0, BR_EQZ, 0, 0, 0, 16'h0002, 0, 16'h0000);
    tbl[2]  = mk(OP_ADD,  16'h0000, 16'h0000, 16'hFFFC, 16'h0010, 1, BR_EQZ, 0, 0, 0, 16'h0000, 1, 16'h000C);
    tbl[3]  = mk(OP_ADD,  16'h0000, 16'h0000, 16'hFFFC, 16'h0010, 1, BR_NEZ, 0, 0, 0, 16'h0000, 0, 16'h0000);
    tbl[4]  = mk(OP_ADD,  16'h1000, 16'h0000, 16'h0004, 16'h0022, 0, BR_EQZ, 1, 1, 1, 16'h0022, 1, 16'h1004);
    tbl[5]  = mk(OP_SLT,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 0, BR_EQZ, 0, 0, 0, 16'h0001, 0, 16'h0000);
    tbl[6]  = mk(OP_SLE,  16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 0, BR_EQZ, 0, 0, 0, 16'h0000, 0, 16'h0000);
    tbl[7]  = mk(OP_SEQ,  16'h0005, 16'h0005, 16'h0000, 16'h0000, 0, BR_EQZ, 0, 0, 0, 16'h0001, 0, 16'h0000);
    tbl[8]  = mk(OP_SCO,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 0, BR_EQZ, 0, 0, 0, 16'h0001, 0, 16'h0000);
    tbl[9]  = mk(OP_ROL,  16'h8001, 16'h0001, 16'h0000, 16'h0000, 0, BR_EQZ, 0, 0, 0, 16'h0003, 0, 16'h0000);
    tbl[10] = mk(OP_ROR,  16'h0001, 16'h0004, 16'h0000, 16'h0000, 0, BR_EQZ, 0, 0, 0, 16'h1000, 0, 16'h0000);
    tbl[11] = mk(OP_SRL,  16'h8000, 16'h000F, 16'h0000, 16'h0000, 0, BR_EQZ, 0, 0, 0, 16'h0001, 0, 16'h0000);
    tbl[12] = mk(OP_SLL,  16'h0001, 16'h0013, 16'h0000, 16'h0000, 0, BR_EQZ, 0, 0, 0, 16'h0008, 0, 16'h0000);
    tbl[13] = mk(OP_BTR,  16'h0001, 16'h0000, 16'h0000, 16'h0000, 0, BR_EQZ, 0, 0, 0, 16'h8000, 0, 16'h0000);
    tbl[14] = mk(OP_LBI,  16'h0000, 16'h0000, 16'h1234, 16'h0000, 0, BR_EQZ, 0, 0, 0, 16'h1234, 0, 16'h0000);
    tbl[15] = mk(OP_SLBI, 16'h0012, 16'h0000, 16'hFF34, 16'h0000, 0, BR_EQZ, 0, 0, 0, 16'h1234, 0, 16'h0000);
    tbl[16] = mk(OP_ANDN, 16'hFF0F, 16'h00FF, 16'h0000, 16'h0000, 0, BR_EQZ, 0, 0, 0, 16'hFF00, 0, 16'h0000);
    tbl[17] = mk(OP_XOR,  16'hF0F0, 16'hFF00, 16'h0000, 16'h0000, 0, BR_EQZ, 0, 0, 0, 16'h0FF0, 0, 16'h0000);
    tbl[18] = mk(OP_ADD,  16'h8000, 16'h0000, 16'h0010, 16'h0100, 1, BR_LTZ, 0, 0, 0, 16'h8000, 1, 16'h0110);
    tbl[19] = mk(OP_ADD,  16'h8000, 16'h0000, 16'h0010, 16'h0100, 1, BR_GEZ, 0, 0, 0, 16'h8000, 0, 16'h0000);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_result", 32'(out_result), 32'd0);
    chk("rst out_rd", 32'(out_rd), 32'd0);
    chk("rst out_wr_en", 32'(out_wr_en), 32'd0);
    chk("rst redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst redirect_pc", 32'(redirect_pc), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst = 1'b1;

    // Directed table, issued back to back
    for (int i = 0; i < 20; i++) begin
      v = tbl[i];
      v.rd = 3'(i % 8);
      v.wr = 1'(i % 2);
      run_vec(v, $sformatf("vec%0d", i));
    end
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk);
    #1 chk("drain out_valid", 32'(out_valid), 32'd0);

    do_mul(16'h0007, 16'h0009, 3'd4, "mul7x9");
    do_mul(16'hFFFF, 16'h0002, 3'd2, "mulFFFFx2");

    // Stall holding a taken SLT result
    v = mk(OP_SLT, 16'hFFFF, 16'h0001, 16'h0010, 16'h0200, 0, BR_EQZ, 1, 0, 0, 16'h0001, 1, 16'h0210);
    v.rd = 3'd6; v.wr = 1'b1;
    run_vec(v, "stall_setup");
    @(negedge clk);
    out_stall = 1'b1;
    in_op = OP_ADD; in_a = 16'h0001; in_b = 16'h0001; in_jmp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("stall%0d in_ready", k), 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d result", k), 32'(out_result), 32'd1);
      chk($sformatf("stall%0d rd", k), 32'(out_rd), 32'd6);
      chk($sformatf("stall%0d redirect_valid", k), 32'(redirect_valid), 32'd0);
      @(negedge clk);
    end
    out_stall = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1 chk("stall release drain", 32'(out_valid), 32'd0);

    // Flush has priority over stall
    v = mk(OP_ADD, 16'h0001, 16'h0002, 16'h0, 16'h0, 0, BR_EQZ, 0, 0, 0, 16'h0003, 0, 16'h0);
    run_vec(v, "flush_stall_setup");
    @(negedge clk);
    in_valid = 1'b0; out_stall = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 chk("flush over stall out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    flush = 1'b0; out_stall = 1'b0;

    // Instruction presented with flush is not accepted
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1;
    #1 chk("flush in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 chk("flush no accept", 32'(out_valid), 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;

    // Flush during MUL cycle 5
    start_mul(16'h1234, 16'h0005, 3'd1);
    repeat (4) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    #1 chk("flush mul in_ready", 32'(in_ready), 32'd1);
    watch_no_valid(20, "flush mul no out_valid");

    // Reset mid-stall clears all outputs
    v = mk(OP_ADD, 16'h0004, 16'h0004, 16'h0002, 16'h0040, 0, BR_EQZ, 1, 0, 0, 16'h0008, 1, 16'h0042);
    v.rd = 3'd5; v.wr = 1'b1;
    run_vec(v, "rst_stall_setup");
    @(negedge clk);
    in_valid = 1'b0; out_stall = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst stall out_valid", 32'(out_valid), 32'd0);
    chk("rst stall out_result", 32'(out_result), 32'd0);
    chk("rst stall out_rd", 32'(out_rd), 32'd0);
    chk("rst stall out_wr_en", 32'(out_wr_en), 32'd0);
    chk("rst stall redirect_pc", 32'(redirect_pc), 32'd0);
    @(negedge clk);
    rst = 1'b1; out_stall = 1'b0;

    // Reset mid-MUL aborts with no result
    start_mul(16'h00FF, 16'h0003, 3'd3);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    watch_no_valid(20, "rst mul no out_valid");

    // Random instructions against the reference model
    for (int n = 0; n < 150; n++) begin
      v.op   = op_t'(4'($urandom_range(0, 15)));
      v.a    = 16'($urandom);
      v.b    = 16'($urandom);
      v.imm  = 16'($urandom);
      v.pc   = 16'($urandom);
      v.br   = 1'($urandom);
      v.cond = brch_cond_t'(2'($urandom));
      v.jmp  = ($urandom_range(0, 3) == 0);
      v.jreg = 1'($urandom);
      v.link = v.jmp && 1'($urandom);
      v.rd   = 3'($urandom);
      v.wr   = 1'($urandom);
      if (($urandom_range(0, 3) == 0) && (v.a[15:14] == 2'b00)) v.a = 16'h0000;
      if (v.op == OP_MUL) begin
        do_mul(v.a, v.b, v.rd, $sformatf("rnd%0d mul", n));
      end else begin
        v.exp_res   = v.link ? v.pc : m_alu(v.op, v.a, v.b, v.imm);
        v.exp_redir = m_taken(v.br, v.cond, v.jmp, v.a);
        v.exp_pc    = 16'((longint'(v.jreg ? v.a : v.pc) + longint'(v.imm)) % 65536);
        run_vec(v, $sformatf("rnd%0d op%0d", n, v.op));
      end
    end
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_pipe.md
Name: execute_pipe

Overview:
- Parametrised, registered execute stage for the pipelined processor. It is the successor to the single-cycle combinational execute stage.
- Sits between the ID/EX and EX/MEM boundaries. It owns the EX/MEM output register, a valid/ready handshake, branch/jump resolution with a redirect pulse, and an iterative multi-cycle multiply.
- Datapath width is generic.

Parameters:
- WIDTH, 16, datapath and PC width in bits; must be 8..32 and a power of two.
- RD_W, 3, destination-register index width.
- MUL_EN, 1, 1 = MUL op implemented; 0 = MUL decodes as ADD.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low (asserted when 0, sampled on the clk edge)
- in_valid  in  1  ID/EX holds a valid instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_op  in  4  operation code (exec_pkg::op_t)
- in_a  in  WIDTH  register operand A
- in_b  in  WIDTH  register operand B
- in_imm  in  WIDTH  sign/zero-extended immediate, already selected by decode
- in_pc_inc  in  WIDTH  PC+2 of the instruction
- in_brch_en  in  1  conditional branch
- in_brch_cond  in  2  00 BEQZ, 01 BNEZ, 10 BLTZ, 11 BGEZ (tested on in_a)
- in_jmp  in  1  unconditional jump
- in_jmp_reg  in  1  jump target = in_a + in_imm; otherwise in_pc_inc + in_imm
- in_link  in  1  write in_pc_inc to rd (JAL/JALR)
- in_rd  in  RD_W  destination register
- in_wr_en  in  1  instruction writes rd
- out_stall  in  1  EX/MEM cannot advance
- flush  in  1  squash the instruction held or in flight in this stage
- out_valid  out  1  EX/MEM register holds a valid result
- out_result  out  WIDTH  ALU result, or pc_inc when linking
- out_rd  out  RD_W  registered in_rd
- out_wr_en  out  1  registered in_wr_en, gated by out_valid
- redirect_valid  out  1  one-cycle pulse: taken branch/jump
- redirect_pc  out  WIDTH  target PC

Behaviour:
- Reset (rst==0 at an edge): state=IDLE. out_valid=0, redirect_valid=0, out_result=0, out_rd=0, out_wr_en=0, redirect_pc=0, multiplier registers=0. The reset value of in_ready is 1.
- Ops and results:
  - ADD a+b; SUB b−a; XOR; ANDN a&~b.
  - ROL/SLL/ROR/SRL shift a by b[log2(WIDTH)−1:0].
  - SEQ/SLT/SLE are signed compares; result is {0…,flag}.
  - SCO = carry of a+b; BTR = bit-reverse a; LBI = imm; SLBI = (a<<8)|imm[7:0].
  - MUL = low WIDTH bits of a*b, unsigned.
  - All arithmetic wraps modulo 2^WIDTH.
- Accept: an instruction is accepted when in_valid && in_ready. in_ready = (state==IDLE) && !(out_valid && out_stall).
- Single-cycle ops:
  - Result, rd, wr_en and out_valid=1 are registered on the accept edge (latency 1).
  - redirect_valid/redirect_pc are registered on the same edge, so the redirect pulse coincides with the first out_valid cycle only.
- Branch taken: in_brch_en && cond(in_a) is true. A jump is always taken. The redirect target is computed as a WIDTH-bit wrapping sum.
- MUL (MUL_EN=1):
  - IDLE→MUL on accept. Shift-add runs one bit per cycle for WIDTH cycles; in_ready=0 throughout.
  - On the final cycle, out_valid=1 and state→IDLE. Accept-to-out_valid latency is WIDTH cycles (16 at default).
  - An EX/MEM result already held under stall keeps holding while the multiply iterates. The multiply completes into EX/MEM only when !(out_valid && out_stall); otherwise it waits in MUL_DONE.
- States: IDLE, MUL, MUL_DONE.
  - MUL_DONE→IDLE when EX/MEM is free, loading the product.
- Stall: while out_valid && out_stall, all out_* hold their values, and redirect_valid holds 0 after its first cycle.
- Drain: when out_valid && !out_stall and there is no new accept, out_valid→0 next edge.
- Flush:
  - Clears out_valid and redirect_valid next edge and aborts MUL/MUL_DONE to IDLE.
  - An instruction presented with flush is not accepted: in_ready is forced 0.
  - flush has priority over stall.
  - rst has priority over flush.
- Simultaneous drain and accept: the new result replaces the old one in the same edge (back-to-back throughput 1/cycle).
- Reset mid-MUL aborts it; no output results.

Decomposition:
- exec_pkg:
  - op_t enum (ADD=0, SUB, XOR, ANDN, ROL, SLL, ROR, SRL, SEQ, SLT, SLE, SCO, BTR, LBI, SLBI, MUL=15).
  - brch_cond_t.
  - state_t.
- One sub-module, exec_mul_iter. It is the parametrised WIDTH-cycle shift-add multiplier with start/busy/done/abort. Its reset matches the parent.
- The ALU and branch condition are combinational logic inside execute_pipe.

Test Plan:
- Reset, then ADD a=0x0005 b=0x0003 -> next cycle out_valid=1, out_result=0x0008, in_ready stays 1; back-to-back SUB a=0x0003 b=0x0005 gives 0x0002 the following cycle.
- BEQZ a=0x0000, pc_inc=0x0010, imm=0xFFFC -> redirect_valid for exactly 1 cycle, redirect_pc=0x000C; BNEZ with the same inputs -> no redirect.
- JALR a=0x1000 imm=0x0004 pc_inc=0x0022 link=1 -> redirect_pc=0x1004, out_result=0x0022.
- MUL a=0x0007 b=0x0009 -> in_ready=0 for the multiply duration, out_result=0x003F exactly 16 cycles after accept; a=0xFFFF b=0x0002 -> 0xFFFE.
- out_stall=1 with SLT a=0xFFFF b=0x0001 held (result 0x0001) for 3 cycles -> outputs stable, in_ready=0, redirect_valid not repeated; release -> drain next edge.
- Flush during MUL cycle 5 -> state IDLE, no out_valid; rst=0 mid-stall -> all outputs 0 next edge.
